// File: rtl/relu_maxpool_layer2_if.sv
// Pixel stream bundle between a conv layer, this ReLU/max-pool stage and
// the next layer: four feature-map words in, four pooled channels out.
interface relu_maxpool_layer2_if #(
   parameter int DATA_W = 36,
   parameter int OUT_W  = 9
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_pix1;
   logic signed [DATA_W-1:0] in_pix2;
   logic signed [DATA_W-1:0] in_pix3;
   logic signed [DATA_W-1:0] in_pix4;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  channel1;
   logic signed [OUT_W-1:0]  channel2;
   logic signed [OUT_W-1:0]  channel3;
   logic signed [OUT_W-1:0]  channel4;
   logic                     frame_done;

   // Producer side: drives pixels, observes pooled results.
   modport master (
      output in_valid, in_pix1, in_pix2, in_pix3, in_pix4,
      input  out_valid, channel1, channel2, channel3, channel4, frame_done
   );

   // Pooling stage side.
   modport slave (
      input  in_valid, in_pix1, in_pix2, in_pix3, in_pix4,
      output out_valid, channel1, channel2, channel3, channel4, frame_done
   );
endinterface

// File: rtl/relu_maxpool_layer2.sv
// ReLU + requantization + 2x2 max pooling over four feature maps in lockstep.
// Even rows fold horizontal pairs into a half-width row buffer; odd rows fold
// their pair with the buffered maximum and emit one pooled pixel per window.
module relu_maxpool_layer2 #(
   parameter int IMG_W = 24,
   parameter int IMG_H = 24,
   parameter int SHIFT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   relu_maxpool_layer2_if.slave bus
);

   localparam int DATA_W = 36;
   localparam int OUT_W  = 9;
   localparam int MAPS   = 4;
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int BUF_N  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
   localparam int BW     = (BUF_N > 1) ? $clog2(BUF_N) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic {
      ROW_EVEN = 1'b0,
      ROW_ODD  = 1'b1
   } row_state_t;

   // ReLU, arithmetic shift, clamp to the unsigned 8-bit range.
   function automatic logic signed [OUT_W-1:0] requant(input logic signed [DATA_W-1:0] x);
      logic signed [DATA_W-1:0] s;
      if (x[DATA_W-1]) begin
         return '0;
      end
      s = x >>> SHIFT;
      if (s > 36'sd255) begin
         return 9'sd255;
      end
      return s[OUT_W-1:0];
   endfunction

   function automatic logic signed [OUT_W-1:0] smax(input logic signed [OUT_W-1:0] a,
                                                    input logic signed [OUT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic                     accept_p0;
   logic [BW-1:0]            idx_p0;
   logic signed [DATA_W-1:0] pix_p0  [MAPS];
   logic signed [OUT_W-1:0]  q_p0    [MAPS];
   logic signed [OUT_W-1:0]  win_p0  [MAPS];
   logic signed [OUT_W-1:0]  pair_p0 [MAPS];
   logic signed [OUT_W-1:0]  rowbuf  [MAPS][BUF_N];

   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   row_state_t               state;

   logic                     vld_p1;
   logic                     fd_p1;
   logic signed [OUT_W-1:0]  ch_p1   [MAPS];

   // Reset wins over in_valid so nothing is consumed while in reset.
   assign accept_p0 = bus.in_valid & ~rst;
   assign idx_p0    = BW'(col >> 1);

   // ---- stage p0: quantize inputs and form the window maximum ----
   // Quantize every map and combine with pair and buffered row maximum.
   always_comb begin
      pix_p0[0] = bus.in_pix1;
      pix_p0[1] = bus.in_pix2;
      pix_p0[2] = bus.in_pix3;
      pix_p0[3] = bus.in_pix4;
      for (int m = 0; m < MAPS; m++) begin
         q_p0[m]   = requant(pix_p0[m]);
         win_p0[m] = smax(smax(pair_p0[m], q_p0[m]), rowbuf[m][idx_p0]);
      end
   end

   // Pair and row-buffer storage; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (accept_p0) begin
         for (int m = 0; m < MAPS; m++) begin
            if (!col[0]) begin
               pair_p0[m] <= q_p0[m];
            end else if (state == ROW_EVEN) begin
               rowbuf[m][idx_p0] <= smax(pair_p0[m], q_p0[m]);
            end
         end
      end
   end

   // ---- stage p1: registered pooled outputs ----
   // Raster counters, row-parity FSM and registered pooled outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         col    <= '0;
         row    <= '0;
         state  <= ROW_EVEN;
         vld_p1 <= 1'b0;
         fd_p1  <= 1'b0;
         for (int m = 0; m < MAPS; m++) begin
            ch_p1[m] <= '0;
         end
      end else begin
         vld_p1 <= 1'b0;
         fd_p1  <= 1'b0;
         if (accept_p0) begin
            // An odd column in an odd row closes a 2x2 window; a trailing odd
            // column or row never reaches this branch.
            if (state == ROW_ODD && col[0]) begin
               vld_p1 <= 1'b1;
               for (int m = 0; m < MAPS; m++) begin
                  ch_p1[m] <= win_p0[m];
               end
            end
            if (col == COL_LAST) begin
               col <= '0;
               if (row == ROW_LAST) begin
                  row   <= '0;
                  state <= ROW_EVEN;
                  fd_p1 <= 1'b1;
               end else begin
                  row   <= row + 1'b1;
                  state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   assign bus.out_valid  = vld_p1;
   assign bus.frame_done = fd_p1;
   assign bus.channel1   = ch_p1[0];
   assign bus.channel2   = ch_p1[1];
   assign bus.channel3   = ch_p1[2];
   assign bus.channel4   = ch_p1[3];

endmodule

// File: tb/tb_relu_maxpool_layer2.sv
// Bench for relu_maxpool_layer2: three configurations (4x4 shift 0, 4x4 shift 8,
// 5x5 shift 0) share one stimulus stream; each has a frame-array reference model.
`timescale 1ns/1ps
module tb_relu_maxpool_layer2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              vld = 1'b0;
   logic signed [35:0] pix [4];
   int                errors = 0;
   int                checks = 0;
   int                cyc = 0;
   int                base = 0;
   bit                base_arm = 1'b0;
   bit                chk_en = 1'b0;
   int                pulses [3];
   int                fds    [3];
   int                fd_vld [3];
   logic signed [8:0] obs_a [$];
   logic signed [8:0] obs_b [$];
   int                fd_rel_a [$];

   always #5 clk = ~clk;

   // Edge counter used to time frame_done.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference quantizer written as plain integer arithmetic.
   function automatic int qref(input logic signed [35:0] x, input int sh);
      longint v;
      v = x;
      if (v <= 0) return 0;
      v = v / (longint'(1) << sh);
      return (v > 255) ? 255 : int'(v);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int r;
      r = a;
      if (b > r) r = b;
      if (c > r) r = c;
      if (d > r) r = d;
      return r;
   endfunction

   function automatic logic signed [35:0] rnd();
      longint t;
      case ($urandom_range(0, 3))
         0:       t = longint'($urandom_range(0, 2000)) - 1000;
         1:       t = longint'($urandom_range(0, 140000));
         2:       t = -longint'($urandom);
         default: t = longint'({$urandom, $urandom});
      endcase
      return 36'(t);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int W  = (g == 2) ? 5 : 4;
      localparam int H  = (g == 2) ? 5 : 4;
      localparam int SH = (g == 1) ? 8 : 0;

      relu_maxpool_layer2_if bus ();
      assign bus.in_valid = vld;
      assign bus.in_pix1  = pix[0];
      assign bus.in_pix2  = pix[1];
      assign bus.in_pix3  = pix[2];
      assign bus.in_pix4  = pix[3];

      relu_maxpool_layer2 #(.IMG_W(W), .IMG_H(H), .SHIFT(SH)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      int   img [4][H][W];
      int   k = 0;
      logic exp_v = 1'b0;
      logic exp_f = 1'b0;
      int   exp_c [4] = '{default: 0};

      // Compare outputs, then absorb the inputs offered for the coming edge.
      initial forever begin
         @(negedge clk);
         if (chk_en) begin
            check_val($sformatf("c%0d out_valid", g), bus.out_valid, exp_v);
            check_val($sformatf("c%0d frame_done", g), bus.frame_done, exp_f);
            check_val($sformatf("c%0d channel1", g), bus.channel1, exp_c[0]);
            check_val($sformatf("c%0d channel2", g), bus.channel2, exp_c[1]);
            check_val($sformatf("c%0d channel3", g), bus.channel3, exp_c[2]);
            check_val($sformatf("c%0d channel4", g), bus.channel4, exp_c[3]);
            if (bus.out_valid === 1'b1) begin
               pulses[g]++;
               if (g == 0) obs_a.push_back(bus.channel1);
               if (g == 1) obs_b.push_back(bus.channel1);
               if (bus.frame_done === 1'b1) fd_vld[g]++;
            end
            if (bus.frame_done === 1'b1) begin
               fds[g]++;
               if (g == 0) fd_rel_a.push_back(cyc - base + 2);
            end
         end
         if (rst) begin
            k     = 0;
            exp_v = 1'b0;
            exp_f = 1'b0;
            exp_c = '{default: 0};
         end else if (vld) begin
            int r, c;
            r = k / W;
            c = k % W;
            for (int m = 0; m < 4; m++) img[m][r][c] = qref(pix[m], SH);
            exp_f = (k == W * H - 1);
            exp_v = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (H / 2)) && (c < 2 * (W / 2));
            if (exp_v) begin
               for (int m = 0; m < 4; m++)
                  exp_c[m] = max4(img[m][r-1][c-1], img[m][r-1][c], img[m][r][c-1], img[m][r][c]);
            end
            k = (k + 1) % (W * H);
         end else begin
            exp_v = 1'b0;
            exp_f = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      vld = 1'b0;
      repeat (n) step();
   endtask

   task automatic put(input logic signed [35:0] p0, input bit gaps);
      int g;
      g = 0;
      while (gaps && g < 4 && $urandom_range(0, 1) == 1) begin
         vld = 1'b0;
         for (int m = 0; m < 4; m++) pix[m] = rnd();
         step();
         g++;
      end
      vld    = 1'b1;
      pix[0] = p0;
      for (int m = 1; m < 4; m++) pix[m] = rnd();
      if (base_arm) begin
         base     = cyc + 1;
         base_arm = 1'b0;
      end
      step();
      vld = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = 1'($urandom_range(0, 1));
      for (int m = 0; m < 4; m++) pix[m] = rnd();
      step();
      rst = 1'b0;
      vld = 1'b0;
   endtask

   task automatic clear_rec();
      pulses = '{default: 0};
      fds    = '{default: 0};
      fd_vld = '{default: 0};
      obs_a.delete();
      obs_b.delete();
      fd_rel_a.delete();
   endtask

   function automatic int get_a(input int i);
      return (i < obs_a.size()) ? int'(obs_a[i]) : -999;
   endfunction

   function automatic int get_b(input int i);
      return (i < obs_b.size()) ? int'(obs_b[i]) : -999;
   endfunction

   task automatic check_ramp(input string tag);
      int ref_w [4] = '{5, 7, 13, 15};
      check_val({tag, " pulses"}, obs_a.size(), 4);
      for (int i = 0; i < 4; i++) check_val({tag, " ch1"}, get_a(i), ref_w[i]);
   endtask

   initial begin
      logic signed [35:0] sat_t [8] = '{-1000, 300, -5, -7, 70000, 5, -1, -123456};
      for (int m = 0; m < 4; m++) pix[m] = '0;
      pulses = '{default: 0};
      fds    = '{default: 0};
      fd_vld = '{default: 0};
      rst = 1'b1;
      repeat (3) step();
      chk_en = 1'b1;
      idle(2);
      rst = 1'b0;

      // Window maximum on a raster ramp, continuous valid.
      clear_rec();
      for (int i = 0; i < 16; i++) put(36'(i), 1'b0);
      idle(3);
      check_ramp("ramp");
      check_val("ramp frame_done count", fds[0], 1);
      check_val("ramp frame_done with last pulse", fd_vld[0], 1);

      // ReLU and saturation on the shift-8 instance.
      do_reset();
      clear_rec();
      for (int i = 0; i < 16; i++) put((i < 8) ? sat_t[i] : rnd(), 1'b0);
      idle(3);
      check_val("sat pulses", obs_b.size(), 4);
      check_val("sat window", get_b(0), 255);
      check_val("negative window", get_b(1), 0);

      // Same ramp with random idle cycles.
      do_reset();
      clear_rec();
      for (int i = 0; i < 16; i++) put(36'(i), 1'b1);
      idle(3);
      check_ramp("gaps");

      // Odd dimensions on the 5x5 instance.
      do_reset();
      clear_rec();
      for (int i = 0; i < 25; i++) put(rnd(), 1'b1);
      idle(3);
      check_val("odd pulses", pulses[2], 4);
      check_val("odd frame_done count", fds[2], 1);
      check_val("odd frame_done with out_valid", fd_vld[2], 0);

      // Mid-frame reset, then a clean frame.
      do_reset();
      for (int i = 0; i < 6; i++) put(rnd(), 1'b0);
      do_reset();
      clear_rec();
      for (int i = 0; i < 16; i++) put(36'(i), 1'b0);
      idle(3);
      check_ramp("after reset");

      // Back-to-back frames with no bubble.
      do_reset();
      clear_rec();
      base_arm = 1'b1;
      vld = 1'b1;
      for (int i = 0; i < 32; i++) begin
         vld    = 1'b1;
         pix[0] = 36'(i % 16);
         for (int m = 1; m < 4; m++) pix[m] = rnd();
         if (base_arm) begin
            base     = cyc + 1;
            base_arm = 1'b0;
         end
         step();
      end
      idle(3);
      check_val("b2b pulses", pulses[0], 8);
      check_val("b2b frame_done count", fd_rel_a.size(), 2);
      check_val("b2b frame_done 1 cycle", (fd_rel_a.size() > 0) ? fd_rel_a[0] : -1, 17);
      check_val("b2b frame_done 2 cycle", (fd_rel_a.size() > 1) ? fd_rel_a[1] : -1, 33);

      // Random soak across several frames.
      do_reset();
      for (int i = 0; i < 200; i++) put(rnd(), 1'b1);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/relu_maxpool_layer2.md
RELU_MAXPOOL_LAYER2 -- requirements
Module: relu_maxpool_layer2

Interface
REQ-001 Parameter IMG_W, default 24: conv output row length, in pixels per row.
REQ-002 Parameter IMG_H, default 24: conv output rows per frame.
REQ-003 Parameter SHIFT, default 8: right-shift amount for requantization.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port in_valid, input, 1: the four in_pix words are valid this cycle; connects to the producing layer's enable.
REQ-007 Ports in_pix1..in_pix4, input, signed 36 each: one conv output pixel per feature map, in raster order.
REQ-008 Port out_valid, output, 1: the four channel words are valid this cycle; one-cycle pulse per pooled pixel.
REQ-009 Ports channel1..channel4, output, signed 9 each: pooled, requantized pixel per map; connects to the next layer's channel inputs.
REQ-010 Port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 The block SHALL accept an input pixel set only when in_valid=1; idle cycles hold all counters and buffers.
REQ-012 The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), advancing on each accepted set.
REQ-013 At col=IMG_W-1 the column counter SHALL wrap to 0 and the row counter SHALL increment. At row=IMG_H-1 the row counter SHALL also wrap to 0.
REQ-014 Each accepted pixel SHALL be quantized per map as q = min(255, max(0,x) >>> SHIFT), a non-negative 9-bit signed value.
REQ-015 The FSM SHALL have two states: ROW_EVEN and ROW_ODD. The state toggles on every row wrap. On a frame wrap the state returns to ROW_EVEN.
REQ-016 In ROW_EVEN at even col, q SHALL be held in a per-map pair register. At odd col, max(pair, q) SHALL be written to a per-map row buffer at index col/2.
REQ-017 The row buffer SHALL hold floor(IMG_W/2) entries per map.
REQ-018 In ROW_ODD at even col, q SHALL be held in the pair register. At odd col, the block SHALL compute max(pair, q, rowbuf[col/2]).
REQ-019 The REQ-018 result SHALL be registered onto channelN with out_valid=1 exactly one cycle after the accepting edge.
REQ-020 out_valid SHALL be 0 in every other cycle, and channelN SHALL hold its last value while out_valid=0.
REQ-021 If IMG_W is odd, the last column of each row SHALL be consumed but discarded. If IMG_H is odd, the last row SHALL be consumed with no output.
REQ-022 frame_done SHALL be 1 in the cycle after the set at row=IMG_H-1, col=IMG_W-1 is accepted. When that set also completes a window, frame_done SHALL coincide with out_valid.
REQ-023 Each frame SHALL produce exactly floor(IMG_W/2)*floor(IMG_H/2) out_valid pulses, in raster order of the pooled map.
REQ-024 Back-to-back frames with in_valid held at 1 SHALL be supported with no bubble.
REQ-025 The four maps SHALL be processed identically and in lockstep, with no cross-map interaction.

Reset
REQ-026 While rst=1: counters=0, state=ROW_EVEN, out_valid=0, frame_done=0, channel1..4=0, and in_valid is ignored.
REQ-027 Row buffer and pair register contents need not be cleared, because each entry is written before it is read within a frame.
REQ-028 Reset asserted mid-frame SHALL abandon the partial frame. The first set accepted after rst deasserts is pixel (0,0) of a new frame.

Verification
REQ-029 Scenario, window maximum: IMG_W=IMG_H=4, SHIFT=0, in_pix1 = row*4+col, with in_valid held at 1 for 16 cycles.
- channel1 = 5, 7, 13, 15 on four out_valid pulses.
- The pulses come 1 cycle after cols 1 and 3 of rows 1 and 3.
- frame_done is high together with the last pulse.
REQ-030 Scenario, ReLU and saturation: SHIFT=8, window values (-1000, 300, 70000, 5).
- channel = 255, from saturation.
- A window of all-negative values gives channel = 0.
REQ-031 Scenario, gaps: the same stimulus as REQ-029 with in_valid=0 inserted randomly on about 50% of cycles.
- Identical output sequence.
- Each out_valid is exactly 1 cycle after its completing accepted set.
REQ-032 Scenario, odd dimensions: IMG_W=5, IMG_H=5, 25 accepted sets.
- Exactly 4 out_valid pulses.
- Column 4 and row 4 do not affect any output.
- frame_done pulses once, without out_valid.
REQ-033 Scenario, mid-frame reset: rst=1 for 1 cycle after 6 accepted sets, then a full 4x4 frame.
- All outputs are 0 during reset.
- The following frame matches REQ-029 exactly.
REQ-034 Scenario, back-to-back frames: two 4x4 frames with in_valid continuously 1.
- 8 out_valid pulses.
- frame_done at cycles 17 and 33 relative to the first accepting edge.
